// File: rtl/qpsk_pkg.sv
// Shared QPSK constants: nominal amplitude, symbol codes, default erasure threshold
// and the packed output byte record used by the demapper.
package qpsk_pkg;

  localparam int QPSK_AMP = 50;

  // Symbol codes by quadrant (I sign, Q sign): b1 = Q<0, b0 = (I<0)^(Q<0)
  localparam logic [1:0] SYM_PP = 2'b00;
  localparam logic [1:0] SYM_NP = 2'b01;
  localparam logic [1:0] SYM_NN = 2'b10;
  localparam logic [1:0] SYM_PN = 2'b11;

  localparam int ERASE_THR_DEF = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] nsym;
    logic       last;
  } out_byte_t;

endpackage

// File: rtl/qpsk_demapper_if.sv
// Symbol-in / byte-out streams of the QPSK demapper.
// Handshake: a beat transfers on a rising clk edge where valid && ready; the source
// holds payload stable while valid && !ready, and valid never waits on ready.
interface qpsk_demapper_if;
  logic signed [7:0] s_i;
  logic signed [7:0] s_q;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic        [7:0] m_data;
  logic        [2:0] m_nsym;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_i, s_q, s_valid, s_last, m_ready,
    output s_ready, m_data, m_nsym, m_last, m_valid
  );

  modport master (
    output s_i, s_q, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_nsym, m_last, m_valid
  );
endinterface

// File: rtl/qpsk_slicer.sv
// Combinational hard slicer: signs of I/Q pick the 2-bit symbol; erasure flag only
// when QPSK_DEMAP_ERASURE_EN is defined (otherwise tied low).
module qpsk_slicer
  import qpsk_pkg::*;
#(
  parameter int THR = ERASE_THR_DEF
) (
  input  logic signed [7:0] smp_i,
  input  logic signed [7:0] smp_q,
  output logic        [1:0] sym,
  output logic              erase
);

  always_comb begin
    sym = SYM_PP;
    case ({smp_q[7], smp_i[7]})
      2'b00:   sym = SYM_PP;
      2'b01:   sym = SYM_NP;
      2'b11:   sym = SYM_NN;
      default: sym = SYM_PN;
    endcase
  end

`ifdef QPSK_DEMAP_ERASURE_EN
  logic [8:0] mag_i;
  logic [8:0] mag_q;

  // 9-bit magnitude so that -128 maps to 128 rather than wrapping
  assign mag_i = smp_i[7] ? (9'd0 - {smp_i[7], smp_i}) : {1'b0, smp_i};
  assign mag_q = smp_q[7] ? (9'd0 - {smp_q[7], smp_q}) : {1'b0, smp_q};
  assign erase = (mag_i < 9'(THR)) || (mag_q < 9'(THR));
`else
  localparam int unused_thr = THR;
  assign erase = 1'b0;
`endif

endmodule

// File: rtl/qpsk_demapper.sv
// QPSK demapper: slices I/Q samples, packs four symbols per byte (first in [1:0]),
// flushes short bytes on s_last. Erasure counter enabled by QPSK_DEMAP_ERASURE_EN.
module qpsk_demapper
  import qpsk_pkg::*;
#(
  parameter int ERASE_THR = ERASE_THR_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  qpsk_demapper_if.slave   bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] erase_cnt
);

  logic [1:0] sym;
  logic       erase;
  logic [7:0] acc;
  logic [7:0] acc_new;
  logic [1:0] cnt;
  logic       s_ready;
  logic       accept;
  logic       complete;
  logic       valid_q;
  out_byte_t  obuf;

  qpsk_slicer #(.THR(ERASE_THR)) u_slicer (
    .smp_i (bus.s_i),
    .smp_q (bus.s_q),
    .sym   (sym),
    .erase (erase)
  );

  // Only a held, unconsumed byte stalls the input
  assign s_ready     = !valid_q || bus.m_ready;
  assign bus.s_ready = s_ready;
  assign accept      = bus.s_valid && s_ready;
  assign complete    = accept && ((cnt == 2'd3) || bus.s_last);

  always_comb begin
    acc_new = acc;
    case (cnt)
      2'd0:    acc_new[1:0] = sym;
      2'd1:    acc_new[3:2] = sym;
      2'd2:    acc_new[5:4] = sym;
      default: acc_new[7:6] = sym;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      cnt <= '0;
    end else if (complete) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_new;
      cnt <= cnt + 2'd1;
    end
  end

  // A completing symbol reloads the register even in the cycle the old byte leaves
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      obuf    <= '0;
      valid_q <= 1'b0;
    end else if (complete) begin
      obuf.data <= acc_new;
      obuf.nsym <= {1'b0, cnt} + 3'd1;
      obuf.last <= bus.s_last;
      valid_q   <= 1'b1;
    end else if (valid_q && bus.m_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.m_data  = obuf.data;
  assign bus.m_nsym  = obuf.nsym;
  assign bus.m_last  = obuf.last;
  assign bus.m_valid = valid_q;

`ifdef QPSK_DEMAP_ERASURE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      erase_cnt <= '0;
    end else if (clr_cnt) begin
      erase_cnt <= '0;
    end else if (accept && erase && (erase_cnt != {CNT_W{1'b1}})) begin
      erase_cnt <= erase_cnt + 1'b1;
    end
  end
`else
  logic unused_erase;
  assign unused_erase = erase ^ clr_cnt;
  assign erase_cnt    = '0;
`endif

endmodule

// File: doc/qpsk_demapper.md
# qpsk_demapper

Receive-side counterpart of the QPSK transmit mapper. It accepts signed 8-bit I/Q symbol samples over a valid/ready stream and hard-slices each to 2 bits using the transmit constellation. It packs four symbols per output byte and presents bytes over a valid/ready stream with frame-end flushing. It sits between the equaliser output and the descrambler/deinterleaver.

## Interface
Parameters:
- ERASE_THR, 16: magnitude below which an I or Q component marks a low-confidence symbol. Used only with the erasure feature.
- CNT_W, 16: width of the erasure counter.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  reset, asynchronous and active-low.
- s_i  in  8  signed I sample.
- s_q  in  8  signed Q sample.
- s_valid  in  1  sample valid.
- s_last  in  1  last symbol of frame; qualified by s_valid.
- s_ready  out  1  demapper can accept a sample.
- m_data  out  8  packed bits; first symbol in [1:0], fourth in [7:6].
- m_nsym  out  3  valid symbols in m_data (1–4).
- m_last  out  1  byte closes a frame.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts byte.
- clr_cnt  in  1  synchronous clear of erasure counter.
- erase_cnt  out  CNT_W  erasure count.

## Operation
- Slicing (zero counts as non-negative):
  - I≥0,Q≥0 → 2'b00
  - I<0,Q≥0 → 2'b01
  - I<0,Q<0 → 2'b10
  - I≥0,Q<0 → 2'b11
  - Equivalently, b1 = Q<0 and b0 = (I<0) XOR (Q<0).
- Sample accepted when s_valid && s_ready. s_ready = !m_valid || m_ready. The block stalls only while an unconsumed byte is held.
- Accumulator acc[7:0] and symbol count cnt[1:0]. An accepted symbol is written to acc[2*cnt+1 : 2*cnt].
- Byte completes when cnt==3 or s_last is set on the accepted symbol. On completion:
  - m_data = acc including the new symbol; unfilled upper pairs are zero.
  - m_nsym = cnt+1.
  - m_last = s_last.
  - m_valid = 1.
  - acc and cnt clear.
- Otherwise cnt increments.
- Output handshake: m_valid drops on m_valid && m_ready unless a new byte completes in the same cycle. In that case the register is reloaded and m_valid stays 1.
- Output register holds stable while m_valid && !m_ready.
- s_last on the 4th symbol gives one byte with m_nsym=4 and m_last=1. It produces no extra empty byte.
- Reset (async assert, sync deassert at the block boundary):
  - m_valid=0, m_data=0, m_nsym=0, m_last=0, acc=0, cnt=0, erase_cnt=0.
  - s_ready reads 1 after reset.
  - Reset mid-frame discards the partial byte.

## Timing
- Latency: m_valid rises the cycle after the completing symbol is accepted.
- Full throughput is 1 symbol/cycle in and 1 byte per 4 cycles out, with m_ready held high.
- s_ready is combinational from m_valid and m_ready. There is no combinational path from s_* to m_*.
- Erasure counter updates the cycle after the accepted symbol. clr_cnt has priority over an increment in the same cycle.

## Configuration
- QPSK_DEMAP_ERASURE_EN defined:
  - An accepted symbol is an erasure if |s_i| < ERASE_THR or |s_q| < ERASE_THR.
  - abs is computed 9-bit, so -128 → 128.
  - erase_cnt increments per erasure and saturates at all-ones.
- QPSK_DEMAP_ERASURE_EN undefined: erase_cnt is tied to 0, clr_cnt is ignored, and the comparison logic is absent.
- Data path behaviour is identical in both builds.

## Structure
- Shared package qpsk_pkg holds:
  - QPSK_AMP = 50, the nominal constellation amplitude shared with the transmit mapper.
  - The four 2-bit symbol code constants.
  - The default ERASE_THR.
- One sub-module, qpsk_slicer: combinational; I/Q in, 2-bit decision and erasure flag out.
- qpsk_demapper contains the packer, output register and counter.

## Test plan
- Ideal symbols, m_ready=1: (50,50),(-50,50),(-50,-50),(50,-50) → m_data=8'hE4, m_nsym=4, m_last=0, one cycle after the 4th accept.
- Zero/edge values: (0,0),(0,-1),(-1,0),(-128,127) → m_data=8'h5C, i.e. symbols 00,11,01,01.
- Short frame: 2 symbols (50,50),(-50,-50) with s_last on the 2nd → m_data=8'h08, m_nsym=2, m_last=1; next frame starts at cnt=0.
- Backpressure: hold m_ready=0 after a byte completes → m_data stable, s_ready=0, no samples lost. Release → stream resumes with no duplicated or dropped bytes over 64 random symbols checked against a model.
- Erasure (macro on, ERASE_THR=16): 4 symbols (10,50),(50,-15),(16,-16),(-50,50) → erase_cnt=2. clr_cnt coincident with an erasure → erase_cnt=0. Macro off → erase_cnt stays 0.
- Reset: assert rstn low after 2 accepted symbols → all outputs 0 immediately. After release, 4 new symbols give one byte containing only new data.
